// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

   // Default operand/result width; the iteration count equals this width.
   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, try to
// subtract the divisor, and keep the difference only when it is non-negative.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // The partial remainder stays below the divisor, so WIDTH+1 bits hold the
   // shifted value and the trial difference without losing the borrow.
   assign shifted = {rem_in, dvd_msb};
   assign trial   = shifted - {1'b0, divisor};
   assign q_bit   = ~trial[WIDTH];
   assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with a
// start/busy/done handshake and flush abort. Fixed latency of WIDTH+2 cycles
// from the accept cycle to the done pulse, for every operand pair.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t       state;
   div_state_t       next_state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;        // partial remainder
   logic [WIDTH-1:0] dvd;        // |dividend| shifting out, quotient shifting in
   logic [WIDTH-1:0] dsr;        // |divisor|
   logic [WIDTH-1:0] orig;       // untouched dividend, returned on divide-by-zero
   logic             sign_quo;
   logic             sign_rem;
   logic             dz_pend;
   logic             ovf_pend;

   logic [WIDTH-1:0] dividend_abs;
   logic [WIDTH-1:0] divisor_abs;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

   // Magnitudes are unsigned WIDTH bits, so -MIN maps onto 2^(WIDTH-1) exactly.
   assign dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   assign busy = (state == CALC) || (state == FIX);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .dvd_msb (dvd[WIDTH-1]),
      .divisor (dsr),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic; flush returns to IDLE from any state and beats start.
   always_comb begin
      // NOTE: default assigned first so no path leaves next_state unassigned
      // (which would infer a latch).
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (count == '0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         rem         <= '0;
         dvd         <= '0;
         dsr         <= '0;
         orig        <= '0;
         sign_quo    <= 1'b0;
         sign_rem    <= 1'b0;
         dz_pend     <= 1'b0;
         ovf_pend    <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!flush) begin
            case (state)
               IDLE: begin
                  if (start) begin
                     dvd      <= dividend_abs;
                     dsr      <= divisor_abs;
                     orig     <= dividend;
                     sign_quo <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     sign_rem <= is_signed & dividend[WIDTH-1];
                     dz_pend  <= (divisor == '0);
                     ovf_pend <= is_signed && (dividend == MIN_VAL) && (divisor == '1);
                     rem      <= '0;
                     count    <= CW'(WIDTH - 1);
                  end
               end
               CALC: begin
                  rem   <= step_rem;
                  dvd   <= {dvd[WIDTH-2:0], step_q};
                  count <= count - CW'(1);
               end
               FIX: begin
                  if (dz_pend) begin
                     quotient  <= '1;
                     remainder <= orig;
                  end else if (ovf_pend) begin
                     quotient  <= MIN_VAL;
                     remainder <= '0;
                  end else begin
                     quotient  <= sign_quo ? -dvd : dvd;
                     remainder <= sign_rem ? -rem : rem;
                  end
                  div_by_zero <= dz_pend;
                  overflow    <= ovf_pend;
                  done        <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized
// operands, with a scoreboard queue filled at issue and drained on done.
module tb_seq_divider;

   localparam int W = 32;
   localparam logic [W-1:0] MIN = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          flush;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;
   logic          overflow;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ovf;
      int           cyc;
   } exp_t;

   exp_t          sb[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   logic [W-1:0]  last_q = '0;
   logic [W-1:0]  last_r = '0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .flush       (flush),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference: plain integer division; SV '/' and '%' truncate toward zero,
   // so the remainder takes the dividend's sign as required.
   function automatic exp_t model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint sa;
      longint sd;
      e.dz  = (b == '0);
      e.ovf = sg && (a == MIN) && (b == '1);
      e.cyc = 0;
      if (e.dz) begin
         e.q = '1;
         e.r = a;
      end else if (e.ovf) begin
         e.q = MIN;
         e.r = '0;
      end else if (sg) begin
         sa  = longint'($signed(a));
         sd  = longint'($signed(b));
         e.q = W'(sa / sd);
         e.r = W'(sa % sd);
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   // Drive one request at the current negedge; caller guarantees busy=0.
   task automatic issue(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e     = model(sg, a, b);
      e.cyc = cyc + W + 2;
      sb.push_back(e);
      start     = 1'b1;
      is_signed = sg;
      dividend  = a;
      divisor   = b;
      @(negedge clk);
      start     = 1'b0;
      is_signed = 1'($urandom);
      dividend  = $urandom;
      divisor   = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 64'(busy), 64'(0));
   endtask

   // Monitor: compare every done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(0));
         end else begin
            e = sb.pop_front();
            check("quotient", 64'(quotient), 64'(e.q));
            check("remainder", 64'(remainder), 64'(e.r));
            check("flags", 64'({div_by_zero, overflow}), 64'({e.dz, e.ovf}));
            check("done_cycle", 64'(cyc), 64'(e.cyc));
            last_q = e.q;
            last_r = e.r;
         end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
         check("done_timeout", 64'(cyc), 64'(sb[0].cyc));
         void'(sb.pop_front());
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_q"}, 64'(quotient), 64'(0));
      check({tag, "_r"}, 64'(remainder), 64'(0));
      check({tag, "_flags"}, 64'({div_by_zero, overflow}), 64'(0));
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           sg;

      rst       = 1'b1;
      start     = 1'b0;
      flush     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Unsigned 100/7 with busy window, then back-to-back 50/5 in the done cycle.
      check("busy_c0", 64'(busy), 64'(0));
      issue(1'b0, 32'd100, 32'd7);
      check("busy_c1", 64'(busy), 64'(1));
      repeat (W) @(negedge clk);
      check("busy_c33", 64'(busy), 64'(1));
      @(negedge clk);
      check("busy_c34", 64'(busy), 64'(0));
      check("done_c34", 64'(done), 64'(1));
      issue(1'b0, 32'd50, 32'd5);

      // Requests while busy are ignored (monitor flags any extra done).
      repeat (5) begin
         start    = 1'b1;
         dividend = $urandom;
         divisor  = $urandom;
         @(negedge clk);
      end
      start = 1'b0;
      wait_idle();

      // Signed, overflow and divide-by-zero corners.
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      issue(1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_idle();
      issue(1'b1, MIN, 32'hFFFF_FFFF);
      wait_idle();
      issue(1'b0, 32'h1234, 32'd0);
      wait_idle();
      issue(1'b1, 32'h1234, 32'd0);
      wait_idle();
      @(negedge clk);

      // Flush mid-CALC: busy drops next cycle, no done, results hold.
      issue(1'b0, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'(0));
      void'(sb.pop_back());
      repeat (40) @(negedge clk);
      check("flush_hold_q", 64'(quotient), 64'(last_q));
      check("flush_hold_r", 64'(remainder), 64'(last_r));

      // Flush and start together in IDLE: request dropped.
      flush    = 1'b1;
      start    = 1'b1;
      dividend = 32'd9;
      divisor  = 32'd3;
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      check("flush_start_busy", 64'(busy), 64'(0));
      repeat (40) @(negedge clk);

      // Randomized operands with a mix of back-to-back and gapped issues.
      for (int i = 0; i < 40; i++) begin
         sg = 1'($urandom);
         a  = $urandom;
         case ($urandom_range(0, 5))
            0: b = $urandom;
            1: b = $urandom_range(1, 15);
            2: b = '0;
            3: b = '1;
            4: begin
               a = MIN;
               b = $urandom_range(0, 1) ? '1 : $urandom;
            end
            default: begin
               a = $urandom_range(0, 100000);
               b = $urandom_range(1, 1000);
            end
         endcase
         issue(sg, a, b);
         wait_idle();
         repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) @(negedge clk);
      end
      wait_idle();
      @(negedge clk);

      // Reset in the middle of CALC clears everything.
      issue(1'b1, 32'd12345, 32'hFFFF_FFEF);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      sb.delete();
      last_q = '0;
      last_r = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      issue(1'b0, 32'hFFFF_FFFF, 32'd1);
      wait_idle();
      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
